lcd_bus_arbiter: RTL

- Shares the single LCD controller write port (wr, dr, dbi, direc into the LCD fsm) among N screen generators: menus, mensajes, bat, lista, compras, product readout.
- Replaces static select-based muxing with round-robin arbitration, per-byte handshake and optional burst lock, so a full 16x2 screen refresh is never interleaved.
- Sits between the generator blocks and fsm; all logic runs in the LCD clock domain.

---
 rtl/lcd_bus_arbiter_pkg.sv | 18 +
 rtl/lcd_bus_arbiter_if.sv | 30 +++
 rtl/lcd_bus_arbiter_rr_pick.sv | 30 +++
 rtl/lcd_bus_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types and defaults for the LCD write-port arbiter.
// State encoding is fixed so other blocks and debug probes can decode it.
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        ACK       = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ     = 8;
    localparam int DEF_MAX_BURST = 32;
    localparam int DEF_TIMEOUT   = 4096;
    localparam int DEF_CNT_W     = 12;
    localparam int LCD_ROWS      = 2;
    localparam int LCD_COLS      = 16;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side and LCD-fsm-side signals of the shared LCD write port.
// slave = arbiter view, master = generators plus LCD fsm view.
interface lcd_bus_arbiter_if #(
    parameter int N_REQ = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   lock;
    logic [N_REQ-1:0]   req_dr;
    logic [8*N_REQ-1:0] req_db;
    logic [8*N_REQ-1:0] req_direc;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic               err;
    logic               timeout_sticky;
    logic               lcd_wr;
    logic               lcd_dr;
    logic [7:0]         lcd_dbi;
    logic [7:0]         lcd_direc;
    logic               lcd_done;

    modport slave (
        input  req, lock, req_dr, req_db, req_direc, lcd_done,
        output gnt, ack, err, timeout_sticky, lcd_wr, lcd_dr, lcd_dbi, lcd_direc
    );

    modport master (
        output req, lock, req_dr, req_db, req_direc, lcd_done,
        input  gnt, ack, err, timeout_sticky, lcd_wr, lcd_dr, lcd_dbi, lcd_direc
    );
endinterface

// File: rtl/lcd_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// rr_ptr_i, wrapping at N_REQ; rr_ptr_i itself is checked last.
module lcd_rr_pick #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] winner_o
);
    // rot[j] is the request that sits j+1 places after the pointer
    logic [N_REQ-1:0] rot;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign rot[gi] = req_i[IDX_W'((int'(rr_ptr_i) + 1 + gi) % N_REQ)];
    end

    always_comb begin
        int off;
        off = 0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        valid_o  = |req_i;
        winner_o = IDX_W'((int'(rr_ptr_i) + 1 + off) % N_REQ);
    end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter with burst lock and done-timeout in front of the
// single LCD controller write port; one byte per grant.
module lcd_bus_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BST_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q, rr_ptr_q;
    logic [BST_W-1:0] burst_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] gnt_q, ack_q;
    logic             err_q, sticky_q, wr_q, dr_q;
    logic [7:0]       dbi_q, direc_q;

    logic [7:0]       db_arr    [N_REQ];
    logic [7:0]       direc_arr [N_REQ];
    logic             pick_valid, lock_hit;
    logic [IDX_W-1:0] pick_idx, winner;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign db_arr[gi]    = bus.req_db[8*gi +: 8];
        assign direc_arr[gi] = bus.req_direc[8*gi +: 8];
    end

    lcd_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    // The owner keeps the port only while it still locks and is under the burst limit
    assign lock_hit = bus.lock[owner_q] & bus.req[owner_q] & (int'(burst_q) < MAX_BURST - 1);
    assign winner   = lock_hit ? owner_q : pick_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= IDX_W'(N_REQ - 1);
            burst_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            wr_q     <= 1'b0;
            dr_q     <= 1'b0;
            dbi_q    <= '0;
            direc_q  <= '0;
        end else begin
            wr_q  <= 1'b0;
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q    <= N_REQ'(1) << winner;
                        dr_q     <= bus.req_dr[winner];
                        dbi_q    <= db_arr[winner];
                        direc_q  <= direc_arr[winner];
                        wr_q     <= 1'b1;
                        owner_q  <= winner;
                        rr_ptr_q <= winner;
                        burst_q  <= lock_hit ? burst_q + 1'b1 : '0;
                        cnt_q    <= '0;
                        state_q  <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // done wins over a simultaneous terminal count
                    if (bus.lcd_done || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        ack_q   <= gnt_q;
                        gnt_q   <= '0;
                        dr_q    <= 1'b0;
                        dbi_q   <= '0;
                        direc_q <= '0;
                        state_q <= ACK;
                        if (!bus.lcd_done) begin
                            err_q    <= 1'b1;
                            sticky_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt            = gnt_q;
    assign bus.ack            = ack_q;
    assign bus.err            = err_q;
    assign bus.timeout_sticky = sticky_q;
    assign bus.lcd_wr         = wr_q;
    assign bus.lcd_dr         = dr_q;
    assign bus.lcd_dbi        = dbi_q;
    assign bus.lcd_direc      = direc_q;
endmodule
